// File: rtl/r2sdf_reorder_pkg.sv
// Shared types and helpers for the R2SDF output reorder buffer.
// DTYPE_FIXED_POINT selects Q16.16 samples; otherwise samples are real.
package r2sdf_reorder_pkg;

`ifdef DTYPE_FIXED_POINT
  typedef logic signed [31:0] fpt;
`else
  typedef real fpt;
`endif

  // [1] real part, [0] imaginary part
  typedef fpt cpx [1:0];

  localparam fpt          FPT_ZERO = 0;
  localparam int unsigned BR_W     = 32;

  typedef enum logic {W_IDLE, W_FILL}  wr_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_e;

  // Reverse the low n bits of x; bits at and above n come back as zero.
  function automatic logic [BR_W-1:0] bitrev(input int unsigned n, input logic [BR_W-1:0] x);
    logic [BR_W-1:0] src;
    logic [BR_W-1:0] y;
    src = x;
    y   = '0;
    for (int unsigned i = 0; i < BR_W; i++) begin
      if (i < n) begin
        y   = {y[BR_W-2:0], src[0]};
        src = src >> 1;
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/r2sdf_reorder_bank.sv
// One 2^N-entry complex sample store: synchronous write port, registered read port.
// The read register resets to zero; the storage array itself is never cleared.
module r2sdf_reorder_bank
  import r2sdf_reorder_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_i,
  input  logic [N-1:0] waddr_i,
  input  cpx           wdata_i,
  input  logic         re_i,
  input  logic [N-1:0] raddr_i,
  output cpx           rdata_o
);

  cpx mem_q [2**N];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i][1] <= wdata_i[1];
      mem_q[waddr_i][0] <= wdata_i[0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o[1] <= FPT_ZERO;
      rdata_o[0] <= FPT_ZERO;
    end else if (re_i) begin
      rdata_o[1] <= mem_q[raddr_i][1];
      rdata_o[0] <= mem_q[raddr_i][0];
    end
  end

endmodule

// File: rtl/r2sdf_reorder.sv
// Bit-reversed to natural-order frame reorder buffer at the end of the R2SDF pipeline.
// R2SDF_PINGPONG_EN adds a second bank so writing and draining overlap.
module r2sdf_reorder
  import r2sdf_reorder_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start_ip,
  input  cpx   ip,
  output cpx   op,
  output logic op_valid,
  output logic start_op,
  output logic overrun
);

  localparam logic [N-1:0] LAST = '1;

  wr_state_e    wr_state_q;
  rd_state_e    rd_state_q;
  logic [N-1:0] w_q;
  logic [N-1:0] r_q;
  logic         op_valid_q;
  logic         start_op_q;
  logic         overrun_q;

  logic         draining;
  logic         last_read;
  logic         refuse;
  logic         accept;
  logic         restart;
  logic         fill;
  logic         complete;
  logic         wr_en;
  logic [N-1:0] waddr;

  always_comb begin
    draining  = (rd_state_q == R_DRAIN);
    last_read = draining && (r_q == LAST);
`ifdef R2SDF_PINGPONG_EN
    refuse    = 1'b0;
`else
    // One bank: a new frame may only begin once the final sample is being read out.
    refuse    = start_ip && draining && !last_read;
`endif
    accept    = start_ip && !refuse;
    restart   = accept && (wr_state_q == W_FILL);
    fill      = (wr_state_q == W_FILL) && !start_ip;
    complete  = fill && (w_q == LAST);
    wr_en     = accept || fill;
    waddr     = accept ? '0 : N'(bitrev(N, BR_W'(w_q)));
  end

`ifdef R2SDF_PINGPONG_EN
  logic wb_q;
  logic rb_q;
  logic osel_q;
  cpx   rd0;
  cpx   rd1;
`else
  cpx   rd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      w_q        <= '0;
      r_q        <= '0;
      op_valid_q <= 1'b0;
      start_op_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef R2SDF_PINGPONG_EN
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      osel_q     <= 1'b0;
`endif
    end else begin
      overrun_q <= restart || refuse;

      if (accept) begin
        wr_state_q <= W_FILL;
        w_q        <= N'(1);
      end else if (fill) begin
        w_q <= w_q + 1'b1;
        if (complete) begin
          wr_state_q <= W_IDLE;
`ifdef R2SDF_PINGPONG_EN
          wb_q       <= ~wb_q;
`endif
        end
      end

      op_valid_q <= draining;
      start_op_q <= draining && (r_q == '0);
      if (draining) begin
        r_q <= r_q + 1'b1;
`ifdef R2SDF_PINGPONG_EN
        osel_q <= rb_q;
`endif
        if (last_read) rd_state_q <= R_IDLE;
      end

      // A frame finishing on the last read's edge restarts the drain with no gap.
      if (complete) begin
        rd_state_q <= R_DRAIN;
        r_q        <= '0;
`ifdef R2SDF_PINGPONG_EN
        rb_q       <= wb_q;
`endif
      end
    end
  end

`ifdef R2SDF_PINGPONG_EN
  r2sdf_reorder_bank #(.N(N)) u_bank0 (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_en && !wb_q),
    .waddr_i (waddr),
    .wdata_i (ip),
    .re_i    (draining && !rb_q),
    .raddr_i (r_q),
    .rdata_o (rd0)
  );

  r2sdf_reorder_bank #(.N(N)) u_bank1 (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_en && wb_q),
    .waddr_i (waddr),
    .wdata_i (ip),
    .re_i    (draining && rb_q),
    .raddr_i (r_q),
    .rdata_o (rd1)
  );

  always_comb begin
    op[1] = osel_q ? rd1[1] : rd0[1];
    op[0] = osel_q ? rd1[0] : rd0[0];
  end
`else
  r2sdf_reorder_bank #(.N(N)) u_bank0 (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_en),
    .waddr_i (waddr),
    .wdata_i (ip),
    .re_i    (draining),
    .raddr_i (r_q),
    .rdata_o (rd0)
  );

  always_comb begin
    op[1] = rd0[1];
    op[0] = rd0[0];
  end
`endif

  assign op_valid = op_valid_q;
  assign start_op = start_op_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_r2sdf_reorder.sv
// Scoreboard bench for r2sdf_reorder (N=3 and N=1 instances).
// Expected frame/overrun behaviour follows R2SDF_PINGPONG_EN when it is defined.
module tb_r2sdf_reorder;
  import r2sdf_reorder_pkg::*;

  typedef struct {
    int  cyc;
    real re;
    real im;
    bit  sop;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   edge_n = 0;

  logic st3, v3, so3, ov3;
  cpx   ip3, op3;
  logic st1, v1, so1, ov1;
  cpx   ip1, op1;

  exp_t q3[$];
  exp_t q1[$];
  int   ovq3[$];
  int   ovq1[$];

  int n_chk  = 0;
  int n_pass = 0;

  int br3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  r2sdf_reorder #(.N(3)) u3 (
    .clk(clk), .reset(rst), .start_ip(st3), .ip(ip3),
    .op(op3), .op_valid(v3), .start_op(so3), .overrun(ov3)
  );

  r2sdf_reorder #(.N(1)) u1 (
    .clk(clk), .reset(rst), .start_ip(st1), .ip(ip1),
    .op(op1), .op_valid(v1), .start_op(so1), .overrun(ov1)
  );

  task automatic chk_i(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp, edge_n);
  endtask

  task automatic chk_r(string nm, real got, real exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0.3f expected %0.3f (edge %0d)", nm, got, exp, edge_n);
  endtask

  task automatic cmp_out(string tag, exp_t e, logic sop, real re, real im);
    chk_i({tag, "_cycle"}, edge_n, e.cyc);
    chk_i({tag, "_start_op"}, int'(sop), int'(e.sop));
    chk_r({tag, "_re"}, re, e.re);
    chk_r({tag, "_im"}, im, e.im);
  endtask

  // Monitors: sample on the falling edge, pop an expectation per valid output.
  always @(negedge clk) begin
    if (!rst) begin
      if (v3) begin
        if (q3.size() == 0) chk_i("u3_unexpected_valid", int'(v3), 0);
        else cmp_out("u3_out", q3.pop_front(), so3, op3[1], op3[0]);
      end else if (so3) begin
        chk_i("u3_start_op_without_valid", int'(so3), 0);
      end
      if (ov3) begin
        if (ovq3.size() == 0) chk_i("u3_unexpected_overrun", int'(ov3), 0);
        else chk_i("u3_overrun_cycle", edge_n, ovq3.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (v1) begin
        if (q1.size() == 0) chk_i("u1_unexpected_valid", int'(v1), 0);
        else cmp_out("u1_out", q1.pop_front(), so1, op1[1], op1[0]);
      end else if (so1) begin
        chk_i("u1_start_op_without_valid", int'(so1), 0);
      end
      if (ov1) begin
        if (ovq1.size() == 0) chk_i("u1_unexpected_overrun", int'(ov1), 0);
        else chk_i("u1_overrun_cycle", edge_n, ovq1.pop_front());
      end
    end
  end

  // Inputs change 2 time units after a rising edge and are captured on the next one.
  task automatic drive3(bit s, int val);
    @(posedge clk);
    #2;
    st3    = s;
    ip3[1] = val;
    ip3[0] = -val;
  endtask

  task automatic idle3(int n);
    for (int i = 0; i < n; i++) drive3(1'b0, 0);
  endtask

  task automatic send3(int base, int cnt, output int e0);
    e0 = 0;
    for (int k = 0; k < cnt; k++) begin
      drive3(k == 0, base + k);
      if (k == 0) e0 = edge_n + 1;
    end
  endtask

  task automatic expect3(int e0, int base, int cnt);
    for (int r = 0; r < cnt; r++) begin
      exp_t x;
      x.cyc = e0 + 8 + r;
      x.re  = base + br3[r];
      x.im  = -(base + br3[r]);
      x.sop = (r == 0);
      q3.push_back(x);
    end
  endtask

  task automatic drive1(bit s, int val);
    @(posedge clk);
    #2;
    st1    = s;
    ip1[1] = val;
    ip1[0] = -val;
  endtask

  task automatic pending(string tag);
    chk_i({tag, "_missing_u3_outputs"}, q3.size(), 0);
    chk_i({tag, "_missing_u3_overruns"}, ovq3.size(), 0);
  endtask

  initial begin
    int   e0, e1;
    exp_t x;
    rst = 1'b1;
    st3 = 1'b0; ip3[1] = 0; ip3[0] = 0;
    st1 = 1'b0; ip1[1] = 0; ip1[0] = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_i("reset_op_valid", int'(v3), 0);
    chk_i("reset_start_op", int'(so3), 0);
    chk_i("reset_overrun", int'(ov3), 0);
    chk_r("reset_op_re", op3[1], 0.0);
    idle3(2);

    // Single frame: natural order is 0,4,2,6,1,5,3,7
    send3(0, 8, e0);
    expect3(e0, 0, 8);
    idle3(12);
    pending("single");

    // Back-to-back frames
    send3(0, 8, e0);
    expect3(e0, 0, 8);
`ifdef R2SDF_PINGPONG_EN
    send3(10, 8, e1);
    expect3(e1, 10, 8);
`else
    ovq3.push_back(e0 + 8);
    send3(10, 8, e1);
`endif
    idle3(14);
    pending("b2b");

    // Restart at arrival index 5
    send3(20, 5, e0);
    ovq3.push_back(e0 + 5);
    send3(30, 8, e1);
    expect3(e1, 30, 8);
    idle3(14);
    pending("restart");

    // Reset while output 3 is on op
    send3(40, 8, e0);
    expect3(e0, 40, 4);
    idle3(4);
    @(posedge clk);
    #7 rst = 1'b1;
    #1;
    chk_i("midreset_op_valid", int'(v3), 0);
    chk_i("midreset_start_op", int'(so3), 0);
    chk_i("midreset_overrun", int'(ov3), 0);
    chk_r("midreset_op_re", op3[1], 0.0);
    chk_r("midreset_op_im", op3[0], 0.0);
    pending("midreset");
    @(posedge clk);
    #2 rst = 1'b0;
    idle3(15);
    pending("postreset_quiet");

    // Recovery frame after reset
    send3(50, 8, e0);
    expect3(e0, 50, 8);
    idle3(12);
    pending("recover");

    // N=1: identity mapping, start_op two cycles after start_ip
    drive1(1'b1, 7);
    e0 = edge_n + 1;
    drive1(1'b0, 9);
    x.cyc = e0 + 2; x.re = 7; x.im = -7; x.sop = 1'b1; q1.push_back(x);
    x.cyc = e0 + 3; x.re = 9; x.im = -9; x.sop = 1'b0; q1.push_back(x);
    drive1(1'b0, 0);
    repeat (6) drive1(1'b0, 0);
    chk_i("n1_missing_outputs", q1.size(), 0);
    chk_i("n1_missing_overruns", ovq1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
